// File: rtl/bpu_update_ctrl_pkg.sv
// bpu_update_ctrl_pkg: shared encodings and update payload for the predictor update path
package bpu_update_ctrl_pkg;
  localparam logic [1:0] KIND_DIRECT = 2'b01;
  localparam logic [1:0] KIND_COND   = 2'b10;
  localparam logic [1:0] SEL_ALL     = 2'b11;
  typedef enum logic {ST_CLEAR, ST_RUN} state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic [1:0]  kind;
  } upd_t;
  localparam int PAYLOAD_W = $bits(upd_t);
  function automatic logic kind_legal(input logic [1:0] k);
    return k == KIND_DIRECT || k == KIND_COND;
  endfunction
endpackage

// File: rtl/bpu_upd_fifo.sv
// bpu_upd_fifo: synchronous FIFO with push/pop/flush and occupancy count
module bpu_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 67,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  always_ff @(posedge clk)
    if (push_i && !flush_i) mem_q[wr_q] <= din_i;
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
endmodule

// File: rtl/bpu_update_ctrl.sv
// bpu_update_ctrl: buffers resolved-branch updates onto the table write port and sweeps tables clear
module bpu_update_ctrl
  import bpu_update_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_WID = 5,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               upd_valid_i,
  output logic               upd_ready_o,
  input  logic [1:0]         upd_kind_i,
  input  logic [31:0]        upd_pc_i,
  input  logic [31:0]        upd_target_i,
  input  logic               upd_taken_i,
  input  logic               clear_req_i,
  input  logic               tbl_ready_i,
  output logic               tbl_we_o,
  output logic               tbl_clr_o,
  output logic [1:0]         tbl_sel_o,
  output logic [IDX_WID-1:0] tbl_idx_o,
  output logic [31:0]        tbl_pc_o,
  output logic [31:0]        tbl_target_o,
  output logic               tbl_taken_o,
  output logic               lookup_block_o,
  output logic [CW-1:0]      upd_count_o
);
  state_e             state_q;
  logic [IDX_WID-1:0] clr_cnt_q;
  upd_t               din, head;
  logic               run, full, empty, push, pop, wr_upd, head_ok;
  assign run     = state_q == ST_RUN;
  assign head_ok = kind_legal(head.kind);
  assign wr_upd  = run && !empty && head_ok;
  assign push    = upd_valid_i && upd_ready_o;
  // illegal heads are discarded without waiting on the table port
  assign pop     = run && !empty && (!head_ok || tbl_ready_i);
  assign din     = '{pc: upd_pc_i, target: upd_target_i, taken: upd_taken_i, kind: upd_kind_i};
  bpu_upd_fifo #(.DEPTH(DEPTH), .W(PAYLOAD_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (clear_req_i),
    .din_i   (din),
    .dout_o  (head),
    .count_o (upd_count_o),
    .full_o  (full),
    .empty_o (empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else if (clear_req_i) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else if (!run && tbl_ready_i) begin
      clr_cnt_q <= clr_cnt_q + 1'b1;
      if (&clr_cnt_q) state_q <= ST_RUN;
    end
  assign upd_ready_o    = run && !full;
  assign lookup_block_o = !run;
  assign tbl_clr_o      = !run;
  assign tbl_we_o       = !run || wr_upd;
  assign tbl_sel_o      = !run ? SEL_ALL : (wr_upd ? head.kind : 2'b00);
  assign tbl_idx_o      = run ? '0 : clr_cnt_q;
  assign tbl_pc_o       = wr_upd ? head.pc : '0;
  assign tbl_target_o   = wr_upd ? head.target : '0;
  assign tbl_taken_o    = wr_upd && head.taken;
endmodule
